// File: rtl/csr_trap_ctrl.sv
// -----------------------------------------------------------------------------
// csr_trap_ctrl
//   Sequencer between the pipeline and the machine-mode CSR file.
//   - CSR instructions take a read cycle and a write-back cycle. The old value
//     is returned in the write-back cycle.
//   - A trap writes mepc, mcause and mtval over three cycles. It then
//     redirects the PC to mtvec, or to the vectored entry for interrupts.
//   - An mret redirects the PC to mepc.
//   Only one operation is in flight at a time. New requests are accepted only
//   in IDLE, with priority trap > mret > csr.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   csr_valid/csr_ready               CSR request handshake
//   csr_op/csr_addr/csr_src           op (00 R, 01 RW, 10 RS, 11 RC), address, operand
//   csr_done/csr_result               completion pulse with the old CSR value
//   trap_valid/trap_ack               exception handshake
//   trap_pc/trap_cause/trap_tval      exception info, qualified by trap_valid
//   mret_valid/mret_ack               mret handshake
//   redirect_valid/redirect_pc        one-cycle PC redirect
//   busy                              high while an operation is in flight
//   cf_addr/cf_we/cf_wdata            CSR file shared address/write port
//   cf_rdata/cf_mtvec/cf_mepc         CSR file combinational read data
// -----------------------------------------------------------------------------
module csr_trap_ctrl #(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_valid,
    output logic        csr_ready,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_src,
    output logic        csr_done,
    output logic [31:0] csr_result,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    output logic        trap_ack,
    input  logic        mret_valid,
    output logic        mret_ack,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic [11:0] cf_addr,
    output logic        cf_we,
    output logic [31:0] cf_wdata,
    input  logic [31:0] cf_rdata,
    input  logic [31:0] cf_mtvec,
    input  logic [31:0] cf_mepc
);

    typedef enum logic [2:0] {
        IDLE, CSR_RD, CSR_WR, T_EPC, T_CAUSE, T_TVAL, T_JUMP, RET
    } state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_t      state, state_nxt;
    logic [31:0] t_pc, t_cause, t_tval;
    logic [1:0]  c_op;
    logic [11:0] c_addr;
    logic [31:0] c_src, c_old;
    logic        idle;
    logic        vec_jump;

    // mepc is always word aligned, so its low bits are ignored.
    logic        unused_mepc_lo;
    assign unused_mepc_lo = ^cf_mepc[1:0];

    // Acceptance is only possible in IDLE and never while reset is asserted.
    // Each lower-priority ack is masked by any higher-priority request.
    assign idle      = (state == IDLE);
    assign trap_ack  = idle && !rst && trap_valid;
    assign mret_ack  = idle && !rst && !trap_valid && mret_valid;
    assign csr_ready = idle && !rst && !trap_valid && !mret_valid && csr_valid;
    assign busy      = !idle;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request latches and the captured old CSR value
    always_ff @(posedge clk) begin
        if (rst) begin
            t_pc    <= '0;
            t_cause <= '0;
            t_tval  <= '0;
            c_op    <= '0;
            c_addr  <= '0;
            c_src   <= '0;
            c_old   <= '0;
        end else begin
            if (trap_ack) begin
                t_pc    <= trap_pc;
                t_cause <= trap_cause;
                t_tval  <= trap_tval;
            end
            if (csr_ready) begin
                c_op   <= csr_op;
                c_addr <= csr_addr;
                c_src  <= csr_src;
            end
            if (state == CSR_RD) c_old <= cf_rdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (trap_ack)       state_nxt = T_EPC;
                else if (mret_ack)  state_nxt = RET;
                else if (csr_ready) state_nxt = CSR_RD;
            end
            CSR_RD:  state_nxt = CSR_WR;
            CSR_WR:  state_nxt = IDLE;
            T_EPC:   state_nxt = T_CAUSE;
            T_CAUSE: state_nxt = T_TVAL;
            T_TVAL:  state_nxt = T_JUMP;
            T_JUMP:  state_nxt = IDLE;
            RET:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vectored mode applies to interrupts only (cause MSB set) and mtvec mode 01.
    assign vec_jump = VECTORED_EN && (cf_mtvec[1:0] == 2'b01) && t_cause[31];

    // Output logic
    always_comb begin
        cf_addr        = '0;
        cf_we          = 1'b0;
        cf_wdata       = '0;
        csr_done       = 1'b0;
        csr_result     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state)
            CSR_RD: cf_addr = c_addr;
            CSR_WR: begin
                cf_addr    = c_addr;
                csr_done   = 1'b1;
                csr_result = c_old;
                // Set/clear with a zero operand must not write the CSR.
                unique case (c_op)
                    OP_RW: begin
                        cf_we    = 1'b1;
                        cf_wdata = c_src;
                    end
                    OP_RS: begin
                        cf_we    = |c_src;
                        cf_wdata = c_old | c_src;
                    end
                    OP_RC: begin
                        cf_we    = |c_src;
                        cf_wdata = c_old & ~c_src;
                    end
                    default: begin
                        cf_we    = 1'b0;
                        cf_wdata = c_old;
                    end
                endcase
            end
            T_EPC: begin
                cf_we    = 1'b1;
                cf_addr  = 12'h341;
                cf_wdata = t_pc;
            end
            T_CAUSE: begin
                cf_we    = 1'b1;
                cf_addr  = 12'h342;
                cf_wdata = t_cause;
            end
            T_TVAL: begin
                cf_we    = 1'b1;
                cf_addr  = 12'h343;
                cf_wdata = t_tval;
            end
            T_JUMP: begin
                redirect_valid = 1'b1;
                redirect_pc    = {cf_mtvec[31:2], 2'b00}
                               + (vec_jump ? {t_cause[29:0], 2'b00} : 32'h0);
            end
            RET: begin
                redirect_valid = 1'b1;
                redirect_pc    = {cf_mepc[31:2], 2'b00};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid, csr_ready;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_src;
    logic        csr_done;
    logic [31:0] csr_result;
    logic        trap_valid, trap_ack;
    logic [31:0] trap_pc, trap_cause, trap_tval;
    logic        mret_valid, mret_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [11:0] cf_addr;
    logic        cf_we;
    logic [31:0] cf_wdata, cf_rdata, cf_mtvec, cf_mepc;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Simple CSR file model: combinational reads, write on the rising edge.
    logic [31:0] mem [0:4095];
    assign cf_rdata = mem[cf_addr];
    assign cf_mtvec = mem[12'h305];
    assign cf_mepc  = mem[12'h341];
    always @(posedge clk) if (cf_we) mem[cf_addr] <= cf_wdata;

    always #5 clk = ~clk;

    csr_trap_ctrl #(.VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_src(csr_src), .csr_done(csr_done),
        .csr_result(csr_result),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .trap_ack(trap_ack),
        .mret_valid(mret_valid), .mret_ack(mret_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy),
        .cf_addr(cf_addr), .cf_we(cf_we), .cf_wdata(cf_wdata),
        .cf_rdata(cf_rdata), .cf_mtvec(cf_mtvec), .cf_mepc(cf_mepc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change right after the falling edge; checks follow 1 ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        rst = 1'b1;
        csr_valid = 0; csr_op = 0; csr_addr = 0; csr_src = 0;
        trap_valid = 0; trap_pc = 0; trap_cause = 0; trap_tval = 0;
        mret_valid = 0;

        // Reset holds off any request
        cyc(); cyc();
        trap_valid = 1; csr_valid = 1; #1;
        chk("rst_no_trap_ack", trap_ack, 0);
        chk("rst_no_csr_ready", csr_ready, 0);
        cyc();
        trap_valid = 0; csr_valid = 0; rst = 0; #1;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {cf_we, csr_done, redirect_valid, mret_ack}, 0);
        chk("rst_cf_addr", cf_addr, 0);

        // CSR RS: 0x300 = 0x8, src = 0x80
        mem[12'h300] = 32'h8;
        cyc();
        csr_valid = 1; csr_op = 2'b10; csr_addr = 12'h300; csr_src = 32'h80; #1;
        chk("rs_ready", csr_ready, 1);
        cyc(); csr_valid = 0; #1;
        chk("rs_rd_busy", busy, 1);
        chk("rs_rd_addr", cf_addr, 12'h300);
        chk("rs_rd_nodone", {csr_done, cf_we}, 0);
        cyc(); #1;
        chk("rs_done", csr_done, 1);
        chk("rs_result", csr_result, 32'h8);
        chk("rs_we", cf_we, 1);
        chk("rs_wdata", cf_wdata, 32'h88);
        cyc(); #1;
        chk("rs_mem", mem[12'h300], 32'h88);
        chk("rs_idle", busy, 0);

        // RC with src = 0 on 0x305: no write
        mem[12'h305] = 32'h8000_0001;
        csr_valid = 1; csr_op = 2'b11; csr_addr = 12'h305; csr_src = 0; #1;
        chk("rc_ready", csr_ready, 1);
        cyc(); csr_valid = 0; #1;
        chk("rc_rd_we", cf_we, 0);
        cyc(); #1;
        chk("rc_done", csr_done, 1);
        chk("rc_we", cf_we, 0);
        chk("rc_result", csr_result, 32'h8000_0001);

        // Trap and CSR read together: trap wins, CSR waits
        cyc();
        trap_valid = 1; trap_pc = 32'h100; trap_cause = 32'h2; trap_tval = 32'hDEAD;
        csr_valid = 1; csr_op = 2'b00; csr_addr = 12'h300; csr_src = 0; #1;
        chk("pri_trap_ack", trap_ack, 1);
        chk("pri_csr_wait", csr_ready, 0);
        cyc(); trap_valid = 0; #1;
        chk("t_epc", {cf_we, 8'h0, cf_addr}, {1'b1, 8'h0, 12'h341});
        chk("t_epc_data", cf_wdata, 32'h100);
        chk("t_busy_no_ready", csr_ready, 0);
        cyc(); #1;
        chk("t_cause", {cf_we, 8'h0, cf_addr}, {1'b1, 8'h0, 12'h342});
        chk("t_cause_data", cf_wdata, 32'h2);
        cyc(); #1;
        chk("t_tval", {cf_we, 8'h0, cf_addr}, {1'b1, 8'h0, 12'h343});
        chk("t_tval_data", cf_wdata, 32'hDEAD);
        cyc(); #1;
        chk("t_redir_v", redirect_valid, 1);
        chk("t_redir_pc", redirect_pc, 32'h8000_0000);
        chk("t_jump_we", cf_we, 0);
        chk("t_jump_no_ready", csr_ready, 0);
        cyc(); #1;
        chk("t_mem_epc", mem[12'h341], 32'h100);
        chk("t_mem_tval", mem[12'h343], 32'hDEAD);
        chk("csr_after_trap", csr_ready, 1);
        cyc(); csr_valid = 0;
        cyc(); #1;
        chk("rd_only_done", csr_done, 1);
        chk("rd_only_we", cf_we, 0);
        chk("rd_only_result", csr_result, 32'h88);

        // Vectored interrupt entry
        cyc();
        trap_valid = 1; trap_pc = 32'h204; trap_cause = 32'h8000_0007; trap_tval = 32'h77; #1;
        chk("v_ack", trap_ack, 1);
        cyc(); trap_valid = 0;
        cyc(); cyc(); cyc(); #1;
        chk("v_redir_v", redirect_valid, 1);
        chk("v_redir_pc", redirect_pc, 32'h8000_001C);

        // mret beats csr; redirect to mepc next cycle
        cyc();
        mret_valid = 1; csr_valid = 1; csr_op = 2'b01; csr_addr = 12'h300; csr_src = 1; #1;
        chk("m_ack", mret_ack, 1);
        chk("m_csr_wait", csr_ready, 0);
        cyc(); mret_valid = 0; csr_valid = 0; #1;
        chk("m_redir_v", redirect_valid, 1);
        chk("m_redir_pc", redirect_pc, 32'h204);
        chk("m_we", cf_we, 0);

        // Reset in T_CAUSE aborts the trap
        cyc();
        trap_valid = 1; trap_pc = 32'h300; trap_cause = 32'h5; trap_tval = 32'hBEEF; #1;
        chk("a_ack", trap_ack, 1);
        cyc(); trap_valid = 0;
        cyc(); #1;
        chk("a_in_cause", cf_addr, 12'h342);
        rst = 1;
        cyc(); rst = 0; #1;
        chk("a_busy", busy, 0);
        chk("a_outs", {cf_we, redirect_valid, csr_done}, 0);
        chk("a_cf_addr", cf_addr, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("a_quiet", {cf_we, redirect_valid}, 0);
        end
        chk("a_no_tval_write", mem[12'h343], 32'h77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
